ring_allocator: RTL and testbench

//  Multi-requester circular allocator for a local SRAM buffer of 2^LBW words, serving the read pipeline.
//  N_PORT requesters each ask for a region sized by a config id; a round-robin arbiter grants one per cycle.

---
 rtl/ring_allocator_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/ring_allocator.sv | 157 +++++++++++++++
 tb/tb_ring_allocator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_allocator_pkg.sv
// Shared configuration for the ring allocator: default buffer geometry and helper types.
package ring_allocator_pkg;
  localparam int LOCAL_ADDR_BW0 = 4;
  localparam int N_ICFG = 4;

  typedef logic [LOCAL_ADDR_BW0-1:0] laddr_t;
  typedef logic [LOCAL_ADDR_BW0:0]   lsize_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority starts at the port after the last granted one.
import ring_allocator_pkg::*;

module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = idx_bw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  lo_mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  pick;
  logic [N-1:0]  onehot;

  always_comb begin
    lo_mask = (N'(1) << ptr_q) - N'(1);
    hi_req  = req & ~lo_mask;
    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    pick    = (hi_req != '0) ? hi_req : req;
    onehot  = pick & (~pick + N'(1));
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (onehot[k]) gnt_idx = IW'(k);
    end
    gnt_vld = adv && (req != '0);
    gnt     = gnt_vld ? onehot : '0;
    ptr_d   = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ring_allocator.sv
// Circular region allocator for a 2^LBW-word local buffer; N_PORT requesters, FIFO release,
// single-entry result slot with rdy/ack handshake.
import ring_allocator_pkg::*;

module ring_allocator #(
  parameter int LBW     = LOCAL_ADDR_BW0,
  parameter int N_ICFG  = ring_allocator_pkg::N_ICFG,
  parameter int N_PORT  = 2,
  parameter int ICFG_BW = $clog2(N_ICFG + 1),
  parameter int PBW     = idx_bw(N_PORT)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_ICFG*(LBW+1)-1:0]   i_sizes,
  input  logic [N_PORT-1:0]           alloc_rdy,
  output logic [N_PORT-1:0]           alloc_ack,
  input  logic [N_PORT*ICFG_BW-1:0]   i_alloc_id,
  output logic                        linear_rdy,
  input  logic                        linear_ack,
  output logic [LBW-1:0]              o_linear,
  output logic [ICFG_BW-1:0]          o_linear_id,
  output logic [PBW-1:0]              o_linear_port,
  input  logic                        free_dval,
  input  logic [ICFG_BW-1:0]          i_free_id,
  input  logic                        blkdone_dval,
  output logic [LBW:0]                o_used,
  output logic                        o_err
);

  localparam logic [LBW:0] CAP = {1'b1, {LBW{1'b0}}};

  logic [LBW:0]         size_tab [N_ICFG];
  logic [ICFG_BW-1:0]   port_id  [N_PORT];
  logic [LBW:0]         port_size[N_PORT];
  logic [N_PORT-1:0]    eligible;
  logic [LBW:0]         avail;
  logic [LBW:0]         fsize;

  logic [N_PORT-1:0]    gnt;
  logic [PBW-1:0]       gnt_idx;
  logic                 gnt_vld;
  logic                 slot_free;

  logic [LBW-1:0]       head_q, head_d;
  logic [LBW:0]         used_q, used_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;
  logic [LBW-1:0]       linear_q, linear_d;
  logic [ICFG_BW-1:0]   lid_q, lid_d;
  logic [PBW-1:0]       lport_q, lport_d;
  logic [LBW:0]         asize;
  logic [LBW:0]         used_sum;

  genvar gi;
  generate
    for (gi = 0; gi < N_ICFG; gi++) begin : g_size
      assign size_tab[gi] = i_sizes[gi*(LBW+1) +: (LBW+1)];
    end
    for (gi = 0; gi < N_PORT; gi++) begin : g_id
      assign port_id[gi] = i_alloc_id[gi*ICFG_BW +: ICFG_BW];
    end
  endgenerate

  // Ids outside the size table map to a zero-sized region.
  always_comb begin
    avail = CAP - used_q;
    fsize = '0;
    for (int k = 0; k < N_ICFG; k++) begin
      if (i_free_id == ICFG_BW'(k)) fsize = size_tab[k];
    end
    for (int p = 0; p < N_PORT; p++) begin
      port_size[p] = '0;
      for (int k = 0; k < N_ICFG; k++) begin
        if (port_id[p] == ICFG_BW'(k)) port_size[p] = size_tab[k];
      end
      eligible[p] = alloc_rdy[p] && (avail >= port_size[p]);
    end
  end

  assign slot_free = !rdy_q || linear_ack;

  rr_arbiter #(.N(N_PORT), .IW(PBW)) u_arb (
    .clk     (i_clk),
    .rst     (i_rst),
    .req     (eligible),
    .adv     (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    head_d   = head_q;
    err_d    = err_q;
    rdy_d    = rdy_q;
    linear_d = linear_q;
    lid_d    = lid_q;
    lport_d  = lport_q;
    asize    = gnt_vld ? port_size[gnt_idx] : '0;
    used_sum = used_q + asize;
    used_d   = used_sum;

    if (gnt_vld) begin
      head_d   = head_q + asize[LBW-1:0];
      rdy_d    = 1'b1;
      linear_d = head_q;
      lid_d    = port_id[gnt_idx];
      lport_d  = gnt_idx;
    end else if (linear_ack) begin
      rdy_d = 1'b0;
    end

    // Release more than is outstanding: flag it and clamp rather than wrap.
    if (free_dval) begin
      if (fsize > used_sum) begin
        err_d  = 1'b1;
        used_d = '0;
      end else begin
        used_d = used_sum - fsize;
      end
    end

    if (blkdone_dval) begin
      if ((used_q == '0) && !gnt_vld) head_d = '0;
      else                            err_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q   <= '0;
      used_q   <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      linear_q <= '0;
      lid_q    <= '0;
      lport_q  <= '0;
    end else begin
      head_q   <= head_d;
      used_q   <= used_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      linear_q <= linear_d;
      lid_q    <= lid_d;
      lport_q  <= lport_d;
    end
  end

  assign alloc_ack     = gnt;
  assign linear_rdy    = rdy_q;
  assign o_linear      = linear_q;
  assign o_linear_id   = lid_q;
  assign o_linear_port = lport_q;
  assign o_used        = used_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_ring_allocator.sv
// Bench for ring_allocator: per-cycle vector table with a result scoreboard, plus reset/underflow sequences.
module tb_ring_allocator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [19:0] i_sizes;
  logic [1:0]  alloc_rdy;
  logic [1:0]  alloc_ack;
  logic [2:0]  id0, id1;
  logic        linear_rdy;
  logic        linear_ack;
  logic [3:0]  o_linear;
  logic [2:0]  o_linear_id;
  logic [0:0]  o_linear_port;
  logic        free_dval;
  logic [2:0]  i_free_id;
  logic        blkdone_dval;
  logic [4:0]  o_used;
  logic        o_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  ring_allocator #(.LBW(4), .N_ICFG(4), .N_PORT(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sizes       (i_sizes),
    .alloc_rdy     (alloc_rdy),
    .alloc_ack     (alloc_ack),
    .i_alloc_id    ({id1, id0}),
    .linear_rdy    (linear_rdy),
    .linear_ack    (linear_ack),
    .o_linear      (o_linear),
    .o_linear_id   (o_linear_id),
    .o_linear_port (o_linear_port),
    .free_dval     (free_dval),
    .i_free_id     (i_free_id),
    .blkdone_dval  (blkdone_dval),
    .o_used        (o_used),
    .o_err         (o_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sz(input logic [2:0] id);
    case (id)
      3'd0:    return 4;
      3'd1:    return 8;
      3'd2:    return 16;
      default: return 0;
    endcase
  endfunction

  // Reference model and result scoreboard, evaluated on the falling edge.
  typedef struct {
    int base;
    int id;
    int port;
  } res_t;
  res_t sb[$];

  int   m_head, m_used, m_ptr, m_err;
  logic m_rdy;
  int   gp, p, asz, tmp;
  logic [2:0] pid;
  logic [1:0] exp_gnt;
  res_t r;

  always @(negedge i_clk) begin
    if (i_rst) begin
      m_head = 0; m_used = 0; m_ptr = 0; m_err = 0; m_rdy = 1'b0;
      sb.delete();
    end else begin
      chk("linear_rdy", 32'(linear_rdy), 32'(m_rdy));
      chk("o_used_model", 32'(o_used), m_used);
      if (m_rdy) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          r = sb[0];
          chk("o_linear", 32'(o_linear), r.base);
          chk("o_linear_id", 32'(o_linear_id), r.id);
          chk("o_linear_port", 32'(o_linear_port), r.port);
          if (linear_ack) void'(sb.pop_front());
        end
      end
      gp = -1;
      if (!m_rdy || linear_ack) begin
        for (int k = 0; k < 2; k++) begin
          p   = (m_ptr + k) % 2;
          pid = (p == 0) ? id0 : id1;
          if (gp < 0 && alloc_rdy[p] && (16 - m_used) >= sz(pid)) gp = p;
        end
      end
      exp_gnt = (gp < 0) ? 2'b00 : (gp == 0 ? 2'b01 : 2'b10);
      chk("alloc_ack_model", 32'(alloc_ack), 32'(exp_gnt));
      asz = 0;
      if (gp >= 0) begin
        pid = (gp == 0) ? id0 : id1;
        asz = sz(pid);
        r.base = m_head; r.id = int'(pid); r.port = gp;
        sb.push_back(r);
        $display("grant port=%0d id=%0d base=%0d", gp, pid, m_head);
        m_head = (m_head + asz) % 16;
        m_ptr  = (gp + 1) % 2;
        m_rdy  = 1'b1;
      end else if (linear_ack) begin
        m_rdy = 1'b0;
      end
      tmp = m_used + asz;
      if (free_dval) begin
        if (sz(i_free_id) > tmp) begin m_err = 1; tmp = 0; end
        else tmp = tmp - sz(i_free_id);
      end
      if (blkdone_dval) begin
        if (m_used == 0 && gp < 0) m_head = 0;
        else m_err = 1;
      end
      m_used = tmp;
    end
  end

  typedef struct {
    logic [1:0] rdy;
    logic [2:0] a0, a1;
    logic       lack, fdv;
    logic [2:0] fid;
    logic       blk;
    logic [1:0] exp_ack;
    logic [4:0] exp_used;
    logic       exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rdy, input int a0, input int a1, input logic lack,
                              input logic fdv, input int fid, input logic blk,
                              input logic [1:0] ack, input int used, input logic err);
    vec_t v;
    v.rdy = rdy; v.a0 = 3'(a0); v.a1 = 3'(a1); v.lack = lack; v.fdv = fdv;
    v.fid = 3'(fid); v.blk = blk; v.exp_ack = ack; v.exp_used = 5'(used); v.exp_err = err;
    return v;
  endfunction

  vec_t tbl[34];

  initial begin
    // sequential fill: 4 x id0, wrap, skip-ahead, fairness, backpressure, errors, size 0, full size
    tbl[0]  = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b01,  0, 0);
    tbl[1]  = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b01,  4, 0);
    tbl[2]  = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b01,  8, 0);
    tbl[3]  = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b01, 12, 0);
    tbl[4]  = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 16, 0);
    tbl[5]  = mk(2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 16, 0);
    tbl[6]  = mk(2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 12, 0);
    tbl[7]  = mk(2'b01, 1, 0, 1, 0, 0, 0, 2'b01,  8, 0);
    tbl[8]  = mk(2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 16, 0);
    tbl[9]  = mk(2'b11, 0, 1, 1, 0, 0, 0, 2'b01, 12, 0);
    tbl[10] = mk(2'b11, 0, 1, 1, 1, 0, 0, 2'b00, 16, 0);
    tbl[11] = mk(2'b10, 0, 1, 1, 1, 1, 0, 2'b00, 12, 0);
    tbl[12] = mk(2'b10, 0, 1, 1, 0, 0, 0, 2'b10,  4, 0);
    tbl[13] = mk(2'b11, 0, 0, 1, 1, 0, 0, 2'b01, 12, 0);
    tbl[14] = mk(2'b11, 0, 0, 1, 1, 1, 0, 2'b10, 12, 0);
    tbl[15] = mk(2'b11, 0, 0, 1, 1, 0, 0, 2'b01,  8, 0);
    tbl[16] = mk(2'b11, 0, 0, 1, 1, 0, 0, 2'b10,  8, 0);
    for (int i = 17; i <= 21; i++) tbl[i] = mk(2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 8, 0);
    tbl[22] = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b01,  8, 0);
    tbl[23] = mk(2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 12, 0);
    tbl[24] = mk(2'b00, 0, 0, 1, 1, 0, 0, 2'b00,  8, 0);
    tbl[25] = mk(2'b00, 0, 0, 1, 0, 0, 1, 2'b00,  4, 0);
    tbl[26] = mk(2'b01, 3, 0, 1, 1, 0, 0, 2'b01,  4, 1);
    tbl[27] = mk(2'b00, 0, 0, 1, 0, 0, 1, 2'b00,  0, 1);
    tbl[28] = mk(2'b01, 0, 0, 1, 0, 0, 0, 2'b01,  0, 1);
    tbl[29] = mk(2'b01, 3, 0, 1, 0, 0, 0, 2'b01,  4, 1);
    tbl[30] = mk(2'b01, 2, 0, 1, 1, 3, 0, 2'b00,  4, 1);
    tbl[31] = mk(2'b01, 2, 0, 1, 1, 0, 0, 2'b00,  4, 1);
    tbl[32] = mk(2'b01, 2, 0, 1, 0, 0, 0, 2'b01,  0, 1);
    tbl[33] = mk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 16, 1);

    i_sizes      = {5'd0, 5'd16, 5'd8, 5'd4};
    i_rst        = 1'b1;
    alloc_rdy    = '0;
    id0          = '0;
    id1          = '0;
    linear_ack   = 1'b0;
    free_dval    = 1'b0;
    i_free_id    = '0;
    blkdone_dval = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_linear_rdy", 32'(linear_rdy), 0);
    chk("rst_used", 32'(o_used), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_linear", 32'(o_linear), 0);
    chk("rst_linear_id", 32'(o_linear_id), 0);
    chk("rst_linear_port", 32'(o_linear_port), 0);
    chk("rst_alloc_ack", 32'(alloc_ack), 0);
    i_rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      alloc_rdy = tbl[i].rdy; id0 = tbl[i].a0; id1 = tbl[i].a1; linear_ack = tbl[i].lack;
      free_dval = tbl[i].fdv; i_free_id = tbl[i].fid; blkdone_dval = tbl[i].blk;
      @(negedge i_clk);
      $display("vec %0d: ack=%b used=%0d err=%0d linear_rdy=%0d o_linear=%0d",
               i, alloc_ack, o_used, o_err, linear_rdy, o_linear);
      chk($sformatf("vec%0d_ack", i), 32'(alloc_ack), 32'(tbl[i].exp_ack));
      chk($sformatf("vec%0d_used", i), 32'(o_used), 32'(tbl[i].exp_used));
      chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err));
      @(posedge i_clk);
      #1;
    end
    chk("scoreboard_drained", sb.size(), 0);

    // Reset while a result is pending in the output slot.
    alloc_rdy = 2'b00; linear_ack = 1'b0; free_dval = 1'b1; i_free_id = 3'd2; blkdone_dval = 1'b0;
    @(posedge i_clk); #1;
    alloc_rdy = 2'b01; id0 = 3'd0; free_dval = 1'b0;
    @(posedge i_clk); #1;
    alloc_rdy = 2'b00;
    chk("pre_rst_linear_rdy", 32'(linear_rdy), 1);
    chk("pre_rst_used", 32'(o_used), 4);
    #2 i_rst = 1'b1;
    #1;
    $display("midop reset: linear_rdy=%0d used=%0d err=%0d", linear_rdy, o_used, o_err);
    chk("midrst_linear_rdy", 32'(linear_rdy), 0);
    chk("midrst_used", 32'(o_used), 0);
    chk("midrst_err", 32'(o_err), 0);
    chk("midrst_linear", 32'(o_linear), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Free with nothing outstanding: sticky error, used clamped at zero.
    linear_ack = 1'b1; free_dval = 1'b1; i_free_id = 3'd0;
    @(negedge i_clk);
    chk("uflow_err_before", 32'(o_err), 0);
    @(posedge i_clk); #1;
    free_dval = 1'b0;
    $display("underflow: used=%0d err=%0d", o_used, o_err);
    chk("uflow_err", 32'(o_err), 1);
    chk("uflow_used", 32'(o_used), 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("uflow_err_sticky", 32'(o_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
